add_seq: RTL and testbench

Parametrised multi-cycle adder that computes a WIDTH-bit sum in CHUNK-bit slices, one slice per clock, with a registered carry between slices. It sits behind a valid/ready handshake on both sides, so it drops into datapaths that need wide additions where a full-width carry chain does not meet timing. It adds carry-out and signed-overflow reporting, and an optional subtract mode.

---
 rtl/add_pkg.sv | 20 ++
 rtl/add_chunk.sv | 29 ++
 rtl/add_seq.sv | 132 +++++++++++++
 tb/tb_add_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and helpers for the sequential slice adder.
`timescale 1ns/1ps
package add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Slice counter width; never below one bit so N=1 still has a legal counter.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit.
`timescale 1ns/1ps
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic c_s;

  // Ripple through the low bits, capture the carry into the top bit, then finish.
  always_comb begin
    c_s = ci;
    s   = {CHUNK{1'b0}};
    for (int i = 0; i < CHUNK - 1; i++) begin
      s[i] = x[i] ^ y[i] ^ c_s;
      c_s  = (x[i] & y[i]) | (x[i] & c_s) | (y[i] & c_s);
    end
    c_msb        = c_s;
    s[CHUNK-1]   = x[CHUNK-1] ^ y[CHUNK-1] ^ c_s;
    co           = (x[CHUNK-1] & y[CHUNK-1]) | (x[CHUNK-1] & c_s) | (y[CHUNK-1] & c_s);
  end

endmodule

// File: rtl/add_seq.sv
// Multi-cycle WIDTH-bit adder, one CHUNK-bit slice per clock, valid/ready on both sides.
// Optional subtract mode (sub port, a - b) is enabled by defining ADD_SUB_EN.
`timescale 1ns/1ps
module add_seq
  import add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   bx_q;
  logic               carry_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   sum_q;
  logic               co_q;
  logic               ovf_q;

  logic [WIDTH-1:0]   bx_d;
  logic               cx_d;
  logic [CHUNK-1:0]   slice_d;
  logic               carry_d;
  logic               cmsb_s;

  // Effective operand B and carry-in as captured on the accept edge.
  always_comb begin
`ifdef ADD_SUB_EN
    if (sub) begin
      bx_d = ~b;
      cx_d = 1'b1;
    end else begin
      bx_d = b;
      cx_d = cin;
    end
`else
    bx_d = b;
    cx_d = cin;
`endif
  end

  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x     (a_q[cnt_q*CHUNK +: CHUNK]),
    .y     (bx_q[cnt_q*CHUNK +: CHUNK]),
    .ci    (carry_q),
    .s     (slice_d),
    .co    (carry_d),
    .c_msb (cmsb_s)
  );

  // Control FSM with operand, carry, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      a_q         <= {WIDTH{1'b0}};
      bx_q        <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= {WIDTH{1'b0}};
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            bx_q       <= bx_d;
            carry_q    <= cx_d;
            cnt_q      <= {CNT_W{1'b0}};
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q[cnt_q*CHUNK +: CHUNK] <= slice_d;
          carry_q                     <= carry_d;
          if (cnt_q == LAST) begin
            co_q        <= carry_d;
            ovf_q       <= cmsb_s ^ carry_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_seq.sv
// Randomised self-checking bench for add_seq (WIDTH=16, CHUNK=4) against an arithmetic model.
`timescale 1ns/1ps
module tb_add_seq;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  int checks   = 0;
  int failures = 0;

  add_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb,
                       output logic [15:0] s_e, output logic co_e, output logic ovf_e);
    longint ua, ub, ur, sa, sbv, sr;
    ua  = longint'(av);
    ub  = longint'(bv);
    sa  = longint'($signed(av));
    sbv = longint'($signed(bv));
    if (sb) begin
      ur   = ua - ub;
      sr   = sa - sbv;
      co_e = (ua >= ub);
    end else begin
      ur   = ua + ub + longint'(ci);
      sr   = sa + sbv + longint'(ci);
      co_e = (ur > 65535);
    end
    s_e   = ur[15:0];
    ovf_e = (sr > 32767) || (sr < -32768);
  endtask

  // One transaction; inputs are driven and outputs sampled 1 ns after rising edges.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic sb, input int hold);
    logic [15:0] s_e;
    logic co_e, ovf_e;
    int lat, w;
    logic sb_eff;
`ifdef ADD_SUB_EN
    sb_eff = sb;
`else
    sb_eff = 1'b0;
`endif
    model(av, bv, ci, sb_eff, s_e, co_e, ovf_e);
    out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a = av; b = bv; cin = ci; sub = sb_eff;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    chk("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, N);
    chk("sum", sum, s_e);
    chk("co", co, co_e);
    chk("ovf", ovf, ovf_e);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_sum", {ovf, co, sum}, {ovf_e, co_e, s_e});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
    chk("kept_sum", sum, s_e);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", {ovf, co, sum}, 18'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'hA5C3, 16'h6E17, 1'b1, 1'b0, 5);
    run_op(16'h0F0F, 16'h1111, 1'b0, 1'b0, 0);

    // Reset while two slices have been computed.
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
    in_valid = 1'b1; a = 16'h4444; b = 16'h5555; cin = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_out", {ovf, co, sum}, 18'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

`ifdef ADD_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 2);
`endif

    for (int k = 0; k < 40; k++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
